// File: rtl/cache_set_if.sv
// rtl/cache_set_if.sv - request/response and flush bus of one cache set
// Purpose : groups every cache_set signal except clk/rst.
// Ports   : lookup_en/write_en/way_in/tag_in/offset_in/valid_in/dirty_in/byte_en/data_in
//           and flush_start/flush_ready are driven by the master.
//           hit/hit_way/data_out/victim_* and flush_busy/flush_valid/flush_way/flush_tag
//           are driven by the cache set (slave).
interface cache_set_if #(
    parameter int WAYS         = 4,
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 4
);
    localparam int WB = $clog2(WAYS);

    logic                    lookup_en;
    logic                    write_en;
    logic [WB-1:0]           way_in;
    logic [TAG_WIDTH-1:0]    tag_in;
    logic [OFFSET_WIDTH-1:0] offset_in;
    logic                    valid_in;
    logic                    dirty_in;
    logic [3:0]              byte_en;
    logic [31:0]             data_in;
    logic                    hit;
    logic [WB-1:0]           hit_way;
    logic [31:0]             data_out;
    logic [WB-1:0]           victim_way;
    logic                    victim_dirty;
    logic [TAG_WIDTH-1:0]    victim_tag;
    logic                    flush_start;
    logic                    flush_ready;
    logic                    flush_busy;
    logic                    flush_valid;
    logic [WB-1:0]           flush_way;
    logic [TAG_WIDTH-1:0]    flush_tag;

    modport master (
        output lookup_en, write_en, way_in, tag_in, offset_in, valid_in, dirty_in,
               byte_en, data_in, flush_start, flush_ready,
        input  hit, hit_way, data_out, victim_way, victim_dirty, victim_tag,
               flush_busy, flush_valid, flush_way, flush_tag
    );

    modport slave (
        input  lookup_en, write_en, way_in, tag_in, offset_in, valid_in, dirty_in,
               byte_en, data_in, flush_start, flush_ready,
        output hit, hit_way, data_out, victim_way, victim_dirty, victim_tag,
               flush_busy, flush_valid, flush_way, flush_tag
    );
endinterface

// File: rtl/cache_set.sv
// rtl/cache_set.sv - one N-way cache set with lookup, byte write, victim select and flush walk
// Purpose : tag/valid/dirty/data storage for WAYS ways, registered lookup results,
//           replacement candidate and a dirty-line flush walker.
// Ports   : clk, rst (async active-high), bus (cache_set_if.slave, see interface file).
// Option  : CACHE_SET_LRU_EN selects true LRU ages; otherwise a round-robin pointer
//           that advances on lookup misses.
module cache_set #(
    parameter int WAYS         = 4,
    parameter int TAG_WIDTH    = 20,
    parameter int OFFSET_WIDTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    cache_set_if.slave  bus
);
    localparam int WB    = $clog2(WAYS);
    localparam int WORDS = 1 << OFFSET_WIDTH;
    localparam logic [WB-1:0] LAST_WAY = WB'(WAYS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_OFFER} state_t;

    state_t               state_q, state_d;
    logic [WB-1:0]        scan_q, scan_d;
    logic [WAYS-1:0]      valid_q, valid_d;
    logic [WAYS-1:0]      dirty_q, dirty_d;
    logic [TAG_WIDTH-1:0] tag_q [WAYS];
    logic [TAG_WIDTH-1:0] tag_d [WAYS];
    logic [31:0]          data_q [WAYS][WORDS];

    logic                 hit_q, hit_d;
    logic [WB-1:0]        hit_way_q, hit_way_d;
    logic [31:0]          data_out_q, data_out_d;
    logic [WB-1:0]        victim_way_q, victim_way_d;
    logic                 victim_dirty_q, victim_dirty_d;
    logic [TAG_WIDTH-1:0] victim_tag_q, victim_tag_d;

    logic                 match_any, free_any, wr_go;
    logic [WB-1:0]        match_way, free_way, repl_way;

    // Writes are locked out for the whole flush so the walker never races a refill.
    assign wr_go = bus.write_en && (state_q == S_IDLE);

    // Downward scan leaves the lowest matching / lowest invalid index.
    always_comb begin
        match_any = 1'b0;
        match_way = '0;
        free_any  = 1'b0;
        free_way  = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (valid_q[i] && (tag_q[i] == bus.tag_in)) begin
                match_any = 1'b1;
                match_way = WB'(i);
            end
            if (!valid_q[i]) begin
                free_any = 1'b1;
                free_way = WB'(i);
            end
        end
    end

`ifdef CACHE_SET_LRU_EN
    logic [WB-1:0] age_q [WAYS];
    logic [WB-1:0] age_d [WAYS];
    logic [WB-1:0] pivot_a, pivot_b;

    // A lookup hit is applied before a same-cycle write; the reported victim
    // reflects the ages after both updates.
    always_comb begin
        age_d   = age_q;
        pivot_a = '0;
        pivot_b = '0;
        if (bus.lookup_en && match_any) begin
            pivot_a = age_d[match_way];
            for (int j = 0; j < WAYS; j++)
                if (age_d[j] < pivot_a) age_d[j] = age_d[j] + 1'b1;
            age_d[match_way] = '0;
        end
        if (wr_go) begin
            pivot_b = age_d[bus.way_in];
            for (int j = 0; j < WAYS; j++)
                if (age_d[j] < pivot_b) age_d[j] = age_d[j] + 1'b1;
            age_d[bus.way_in] = '0;
        end
        repl_way = '0;
        for (int j = 0; j < WAYS; j++)
            if (age_d[j] == LAST_WAY) repl_way = WB'(j);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WAYS; i++) age_q[i] <= WB'(i);
        end else begin
            age_q <= age_d;
        end
    end
`else
    logic [WB-1:0] ptr_q, ptr_d;

    // WAYS is a power of two, so the natural wrap is the modulo.
    always_comb begin
        ptr_d = ptr_q;
        if (bus.lookup_en && !match_any) ptr_d = ptr_q + 1'b1;
        repl_way = ptr_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end
`endif

    always_comb begin
        valid_d        = valid_q;
        dirty_d        = dirty_q;
        tag_d          = tag_q;
        state_d        = state_q;
        scan_d         = scan_q;
        hit_d          = hit_q;
        hit_way_d      = hit_way_q;
        data_out_d     = data_out_q;
        victim_way_d   = victim_way_q;
        victim_dirty_d = victim_dirty_q;
        victim_tag_d   = victim_tag_q;

        // Lookup always sees the state from before this cycle's write.
        if (bus.lookup_en) begin
            hit_d          = match_any;
            hit_way_d      = match_any ? match_way : '0;
            data_out_d     = match_any ? data_q[match_way][bus.offset_in] : 32'h0;
            victim_way_d   = free_any ? free_way : repl_way;
            victim_dirty_d = dirty_q[victim_way_d];
            victim_tag_d   = tag_q[victim_way_d];
        end

        if (wr_go) begin
            valid_d[bus.way_in] = bus.valid_in;
            dirty_d[bus.way_in] = bus.dirty_in;
            tag_d[bus.way_in]   = bus.tag_in;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.flush_start) begin
                    state_d = S_SCAN;
                    scan_d  = '0;
                end
            end
            S_SCAN: begin
                if (valid_q[scan_q] && dirty_q[scan_q]) begin
                    state_d = S_OFFER;
                end else begin
                    valid_d[scan_q] = 1'b0;
                    if (scan_q == LAST_WAY) state_d = S_IDLE;
                    else                    scan_d  = scan_q + 1'b1;
                end
            end
            S_OFFER: begin
                if (bus.flush_ready) begin
                    valid_d[scan_q] = 1'b0;
                    dirty_d[scan_q] = 1'b0;
                    if (scan_q == LAST_WAY) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_SCAN;
                        scan_d  = scan_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            scan_q         <= '0;
            valid_q        <= '0;
            dirty_q        <= '0;
            for (int i = 0; i < WAYS; i++) tag_q[i] <= '0;
            hit_q          <= 1'b0;
            hit_way_q      <= '0;
            data_out_q     <= '0;
            victim_way_q   <= '0;
            victim_dirty_q <= 1'b0;
            victim_tag_q   <= '0;
        end else begin
            state_q        <= state_d;
            scan_q         <= scan_d;
            valid_q        <= valid_d;
            dirty_q        <= dirty_d;
            tag_q          <= tag_d;
            hit_q          <= hit_d;
            hit_way_q      <= hit_way_d;
            data_out_q     <= data_out_d;
            victim_way_q   <= victim_way_d;
            victim_dirty_q <= victim_dirty_d;
            victim_tag_q   <= victim_tag_d;
        end
    end

    // Data words carry no reset; valid bits decide whether they are meaningful.
    always_ff @(posedge clk) begin
        if (wr_go) begin
            for (int b = 0; b < 4; b++)
                if (bus.byte_en[b])
                    data_q[bus.way_in][bus.offset_in][8*b +: 8] <= bus.data_in[8*b +: 8];
        end
    end

    assign bus.hit          = hit_q;
    assign bus.hit_way      = hit_way_q;
    assign bus.data_out     = data_out_q;
    assign bus.victim_way   = victim_way_q;
    assign bus.victim_dirty = victim_dirty_q;
    assign bus.victim_tag   = victim_tag_q;
    // Flush outputs decode straight from state so an async reset drops them at once.
    assign bus.flush_busy   = (state_q != S_IDLE);
    assign bus.flush_valid  = (state_q == S_OFFER);
    assign bus.flush_way    = (state_q == S_OFFER) ? scan_q : '0;
    assign bus.flush_tag    = (state_q == S_OFFER) ? tag_q[scan_q] : '0;
endmodule

// File: tb/tb_cache_set.sv
// tb/tb_cache_set.sv - self-checking bench for cache_set
module tb_cache_set;
    localparam int WAYS  = 4;
    localparam int TW    = 20;
    localparam int OW    = 4;
    localparam int WORDS = 1 << OW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_set_if #(.WAYS(WAYS), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW)) bus ();

    cache_set #(.WAYS(WAYS), .TAG_WIDTH(TW), .OFFSET_WIDTH(OW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: plain arrays plus a most-recent-first list for LRU order.
    bit          m_valid [WAYS];
    bit          m_dirty [WAYS];
    logic [TW-1:0] m_tag [WAYS];
    logic [31:0] m_data  [WAYS][WORDS];
    int          lru_q[$];
    int          rr;
    bit          e_hit;
    int          e_way;
    logic [31:0] e_data;
    int          e_vway;
    bit          e_vdirty;
    logic [TW-1:0] e_vtag;

    typedef struct {
        bit lk; bit wr; int way; logic [TW-1:0] tag; int off; bit vin; bit din;
        logic [3:0] be; logic [31:0] data;
        bit e_hit; int e_way; logic [31:0] e_data; int e_vway; bit e_vdirty; logic [TW-1:0] e_vtag;
    } vec_t;
    vec_t tv [10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    function automatic void touch(input int w);
        for (int k = 0; k < lru_q.size(); k++)
            if (lru_q[k] == w) begin
                lru_q.delete(k);
                break;
            end
        lru_q.push_front(w);
    endfunction

    function automatic int policy_way();
`ifdef CACHE_SET_LRU_EN
        return lru_q[lru_q.size() - 1];
`else
        return rr;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < WAYS; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
            m_tag[i]   = '0;
        end
        lru_q.delete();
        for (int i = 0; i < WAYS; i++) lru_q.push_back(i);
        rr = 0;
        e_hit = 1'b0; e_way = 0; e_data = '0; e_vway = 0; e_vdirty = 1'b0; e_vtag = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic compare_model(input string nm);
        check({nm, "_hit"},    32'(bus.hit),          32'(e_hit));
        check({nm, "_hitway"}, 32'(bus.hit_way),      32'(e_way));
        check({nm, "_data"},   bus.data_out,          e_data);
        check({nm, "_vway"},   32'(bus.victim_way),   32'(e_vway));
        check({nm, "_vdirty"}, 32'(bus.victim_dirty), 32'(e_vdirty));
        check({nm, "_vtag"},   32'(bus.victim_tag),   32'(e_vtag));
    endtask

    // One cycle of lookup and/or write, with the model updated from its rules.
    task automatic step(input string nm, input bit lk, input bit wr, input int way,
                        input logic [TW-1:0] tag, input int off, input bit vin, input bit din,
                        input logic [3:0] be, input logic [31:0] data, input bit cmp);
        bit h, fr;
        int hw, vw;
        @(negedge clk);
        bus.lookup_en = lk;
        bus.write_en  = wr;
        bus.way_in    = 2'(way);
        bus.tag_in    = tag;
        bus.offset_in = 4'(off);
        bus.valid_in  = vin;
        bus.dirty_in  = din;
        bus.byte_en   = be;
        bus.data_in   = data;
        h = 1'b0; hw = 0;
        if (lk)
            for (int i = 0; i < WAYS; i++)
                if (!h && m_valid[i] && m_tag[i] == tag) begin h = 1'b1; hw = i; end
        if (lk && h)  touch(hw);
        if (lk && !h) rr = (rr + 1) % WAYS;
        if (wr)       touch(way);
        if (lk) begin
            fr = 1'b0; vw = 0;
            for (int i = 0; i < WAYS; i++)
                if (!fr && !m_valid[i]) begin fr = 1'b1; vw = i; end
            if (!fr) vw = policy_way();
            e_hit    = h;
            e_way    = h ? hw : 0;
            e_data   = h ? m_data[hw][off] : 32'h0;
            e_vway   = vw;
            e_vdirty = m_dirty[vw];
            e_vtag   = m_tag[vw];
        end
        if (wr) begin
            m_valid[way] = vin;
            m_dirty[way] = din;
            m_tag[way]   = tag;
            for (int b = 0; b < 4; b++)
                if (be[b]) m_data[way][off][8*b +: 8] = data[8*b +: 8];
        end
        @(posedge clk);
        #1;
        bus.lookup_en = 1'b0;
        bus.write_en  = 1'b0;
        if (cmp) compare_model(nm);
    endtask

    task automatic wait_offer(input string nm);
        bit ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.flush_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check({nm, "_offer_timeout"}, 32'(ok), 32'd1);
    endtask

    initial begin
        bus.lookup_en = 0; bus.write_en = 0; bus.way_in = '0; bus.tag_in = '0;
        bus.offset_in = '0; bus.valid_in = 0; bus.dirty_in = 0; bus.byte_en = '0;
        bus.data_in = '0; bus.flush_start = 0; bus.flush_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        do_reset();

        // Give every word a known value; data survives the following reset.
        for (int w = 0; w < WAYS; w++)
            for (int o = 0; o < WORDS; o++)
                step("fill", 1'b0, 1'b1, w, '0, o, 1'b0, 1'b0, 4'hF,
                     32'hF000_0000 | 32'(w << 8) | 32'(o), 1'b0);
        do_reset();
        #1;
        check("rst_hit",         32'(bus.hit),          32'd0);
        check("rst_data",        bus.data_out,          32'd0);
        check("rst_victim_way",  32'(bus.victim_way),   32'd0);
        check("rst_flush_busy",  32'(bus.flush_busy),   32'd0);
        check("rst_flush_valid", 32'(bus.flush_valid),  32'd0);

        tv[0] = '{1'b1, 1'b0, 0, 20'h12345, 0, 1'b0, 1'b0, 4'h0, 32'h0,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[1] = '{1'b0, 1'b1, 2, 20'hABCDE, 3, 1'b1, 1'b0, 4'hF, 32'hDEADBEEF,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[2] = '{1'b0, 1'b1, 2, 20'hABCDE, 3, 1'b1, 1'b1, 4'h1, 32'h00000011,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[3] = '{1'b1, 1'b0, 0, 20'hABCDE, 3, 1'b0, 1'b0, 4'h0, 32'h0,
                  1'b1, 2, 32'hDEADBE11, 0, 1'b0, 20'h0};
        tv[4] = '{1'b1, 1'b1, 0, 20'h00001, 0, 1'b1, 1'b1, 4'hF, 32'h01020304,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[5] = '{1'b1, 1'b0, 0, 20'h00001, 0, 1'b0, 1'b0, 4'h0, 32'h0,
                  1'b1, 0, 32'h01020304, 1, 1'b0, 20'h0};
        tv[6] = '{1'b0, 1'b1, 1, 20'hABCDE, 5, 1'b1, 1'b0, 4'hF, 32'h00000055,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[7] = '{1'b1, 1'b0, 0, 20'hABCDE, 3, 1'b0, 1'b0, 4'h0, 32'h0,
                  1'b1, 1, 32'hF0000103, 3, 1'b0, 20'h0};
        tv[8] = '{1'b0, 1'b1, 3, 20'h12345, 0, 1'b0, 1'b1, 4'h0, 32'h0,
                  1'b0, 0, 32'h0, 0, 1'b0, 20'h0};
        tv[9] = '{1'b1, 1'b0, 0, 20'h12345, 0, 1'b0, 1'b0, 4'h0, 32'h0,
                  1'b0, 0, 32'h0, 3, 1'b1, 20'h12345};
        foreach (tv[i]) begin
            step($sformatf("vec%0d", i), tv[i].lk, tv[i].wr, tv[i].way, tv[i].tag, tv[i].off,
                 tv[i].vin, tv[i].din, tv[i].be, tv[i].data, 1'b1);
            if (tv[i].lk) begin
                check($sformatf("vec%0d_hit", i),    32'(bus.hit),          32'(tv[i].e_hit));
                check($sformatf("vec%0d_hitway", i), 32'(bus.hit_way),      32'(tv[i].e_way));
                check($sformatf("vec%0d_data", i),   bus.data_out,          tv[i].e_data);
                check($sformatf("vec%0d_vway", i),   32'(bus.victim_way),   32'(tv[i].e_vway));
                check($sformatf("vec%0d_vdirty", i), 32'(bus.victim_dirty), 32'(tv[i].e_vdirty));
                check($sformatf("vec%0d_vtag", i),   32'(bus.victim_tag),   32'(tv[i].e_vtag));
            end
        end

        // Replacement policy with every way valid.
        do_reset();
        for (int w = 0; w < WAYS; w++)
            step("pol_fill", 1'b0, 1'b1, w, 20'(32'h100 + w), 0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b1);
`ifdef CACHE_SET_LRU_EN
        for (int w = 0; w < WAYS; w++)
            step("lru_hit", 1'b1, 1'b0, 0, 20'(32'h100 + w), 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        check("lru_victim", 32'(bus.victim_way), 32'd0);
`else
        for (int k = 0; k < 5; k++)
            step("rr_miss", 1'b1, 1'b0, 0, 20'h999, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        check("rr_victim", 32'(bus.victim_way), 32'd1);
`endif

        // Flush walk with a stalled writeback engine.
        do_reset();
        step("fl_fill", 1'b0, 1'b1, 0, 20'hA0, 0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        step("fl_fill", 1'b0, 1'b1, 1, 20'hB1, 0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        step("fl_fill", 1'b0, 1'b1, 2, 20'hC2, 0, 1'b1, 1'b0, 4'h0, 32'h0, 1'b0);
        step("fl_fill", 1'b0, 1'b1, 3, 20'hD3, 0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        bus.flush_start = 1'b1;
        @(negedge clk);
        bus.flush_start = 1'b0;
        check("fl_busy_scan", 32'(bus.flush_busy), 32'd1);
        wait_offer("fl_way1");
        check("fl_way1_way", 32'(bus.flush_way), 32'd1);
        check("fl_way1_tag", 32'(bus.flush_tag), 32'hB1);
        for (int k = 0; k < 3; k++) begin
            bus.write_en = 1'b1; bus.way_in = 2'd0; bus.tag_in = 20'h55;
            bus.valid_in = 1'b1; bus.dirty_in = 1'b1; bus.byte_en = 4'h0;
            @(negedge clk);
            check("fl_hold_valid", 32'(bus.flush_valid), 32'd1);
            check("fl_hold_way",   32'(bus.flush_way),   32'd1);
            check("fl_hold_tag",   32'(bus.flush_tag),   32'hB1);
        end
        bus.write_en    = 1'b0;
        bus.flush_ready = 1'b1;
        wait_offer("fl_way3");
        check("fl_way3_way", 32'(bus.flush_way), 32'd3);
        check("fl_way3_tag", 32'(bus.flush_tag), 32'hD3);
        @(negedge clk);
        bus.flush_ready = 1'b0;
        check("fl_done_busy",  32'(bus.flush_busy),  32'd0);
        check("fl_done_valid", 32'(bus.flush_valid), 32'd0);
        for (int w = 0; w < WAYS; w++) begin
            m_valid[w] = 1'b0;
            m_dirty[w] = 1'b0;
        end
        step("fl_look_a0", 1'b1, 1'b0, 0, 20'hA0, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        step("fl_look_b1", 1'b1, 1'b0, 0, 20'hB1, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        step("fl_look_c2", 1'b1, 1'b0, 0, 20'hC2, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        step("fl_look_d3", 1'b1, 1'b0, 0, 20'hD3, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        step("fl_look_55", 1'b1, 1'b0, 0, 20'h55, 0, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        check("fl_blocked_write_hit", 32'(bus.hit), 32'd0);

        // Reset arriving while a line is being offered.
        do_reset();
        step("ab_fill", 1'b0, 1'b1, 1, 20'h77, 0, 1'b1, 1'b1, 4'h0, 32'h0, 1'b0);
        @(negedge clk);
        bus.flush_start = 1'b1;
        @(negedge clk);
        bus.flush_start = 1'b0;
        wait_offer("ab");
        rst = 1'b1;
        #1;
        check("ab_flush_valid", 32'(bus.flush_valid), 32'd0);
        check("ab_flush_busy",  32'(bus.flush_busy),  32'd0);
        check("ab_flush_way",   32'(bus.flush_way),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step("ab_write", 1'b0, 1'b1, 2, 20'h88, 1, 1'b1, 1'b1, 4'hF, 32'hCAFEF00D, 1'b1);
        step("ab_look",  1'b1, 1'b0, 0, 20'h88, 1, 1'b0, 1'b0, 4'h0, 32'h0, 1'b1);
        check("ab_hit",    32'(bus.hit),     32'd1);
        check("ab_hitway", 32'(bus.hit_way), 32'd2);
        check("ab_data",   bus.data_out,     32'hCAFEF00D);

        // Random traffic against the model; outputs also checked on idle cycles.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            step("rnd", ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                 int'($urandom_range(0, WAYS - 1)), 20'(32'h10 + $urandom_range(0, 5)),
                 int'($urandom_range(0, WORDS - 1)), ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cache_set.md
CACHE_SET -- requirements
Module: cache_set

Interface
REQ-001 SHALL have parameter WAYS, default 4, number of ways (power of two, 2..8); WB = log2(WAYS).
REQ-002 SHALL have parameter TAG_WIDTH, default 20, tag bits per way.
REQ-003 SHALL have parameter OFFSET_WIDTH, default 4, word-offset bits; each way holds 2**OFFSET_WIDTH 32-bit words.
REQ-004 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port lookup_en  in  1  lookup request.
REQ-007 SHALL have port write_en  in  1  write request.
REQ-008 SHALL have port way_in  in  WB  way written.
REQ-009 SHALL have port tag_in  in  TAG_WIDTH  lookup compare tag and write tag.
REQ-010 SHALL have port offset_in  in  OFFSET_WIDTH  word offset for lookup and write.
REQ-011 SHALL have ports valid_in, dirty_in  in  1 each  line flags written.
REQ-012 SHALL have port byte_en  in  4  byte write enables.
REQ-013 SHALL have port data_in  in  32  write data.
REQ-014 SHALL have port hit  out  1  registered lookup hit.
REQ-015 SHALL have port hit_way  out  WB  matching way.
REQ-016 SHALL have port data_out  out  32  hit word, 0 on miss.
REQ-017 SHALL have ports victim_way  out  WB, victim_dirty  out  1, victim_tag  out  TAG_WIDTH  replacement candidate.
REQ-018 SHALL have port flush_start  in  1  start flush walk.
REQ-019 SHALL have port flush_ready  in  1  writeback engine accepts flush_valid.
REQ-020 SHALL have ports flush_busy, flush_valid  out  1 each  flush in progress, dirty line offered.
REQ-021 SHALL have ports flush_way  out  WB, flush_tag  out  TAG_WIDTH  offered dirty line.

Function
REQ-022 SHALL register lookup results: lookup_en at edge N -> hit/hit_way/data_out/victim_* valid after edge N; outputs hold until next lookup.
REQ-023 SHALL assert hit when any valid way's tag equals tag_in; hit_way = lowest matching index; data_out = its word at offset_in.
REQ-024 SHALL choose victim_way = lowest-index invalid way if any, else the replacement-policy way; victim_dirty/victim_tag from that way.
REQ-025 SHALL on write_en (flush_busy low) load valid_in, dirty_in, tag_in into way_in and write enabled bytes of word offset_in.
REQ-026 SHALL give a lookup and write in the same cycle pre-write (read-old) state.
REQ-027 SHALL implement flush FSM IDLE -> SCAN -> OFFER -> SCAN ... -> IDLE; flush_start ignored unless IDLE.
REQ-028 SHALL in SCAN examine one way per cycle from way 0: valid&dirty -> OFFER; else clear valid, next way.
REQ-029 SHALL in OFFER hold flush_valid, flush_way, flush_tag stable until flush_ready; on handshake clear valid and dirty, return to SCAN at next way.
REQ-030 SHALL return to IDLE after way WAYS-1; flush_busy high in SCAN/OFFER only.
REQ-031 SHALL ignore write_en while flush_busy; lookups remain honoured (data readable for writeback).

Reset
REQ-032 SHALL on rst clear all valid/dirty/tag, all outputs to 0, FSM to IDLE, policy state to initial value, aborting any flush; data words are not reset.

Configuration
REQ-033 SHALL with CACHE_SET_LRU_EN defined keep per-way WB-bit ages (reset age[i]=i); a lookup hit or write makes that way age 0 and increments younger ways; replacement way = age WAYS-1.
REQ-034 SHALL without CACHE_SET_LRU_EN use a WB-bit round-robin pointer (reset 0), advanced modulo WAYS on each lookup miss; replacement way = pointer.

Verification
REQ-035 SHALL test: reset, lookup tag 0x12345 -> hit=0, data_out=0, victim_way=0, victim_dirty=0.
REQ-036 SHALL test: write way 2 tag 0xABCDE offset 3 data 0xDEADBEEF byte_en 0xF, then byte_en 0x1 data 0x11 -> lookup hit=1, hit_way=2, data_out=0xDEADBE11.
REQ-037 SHALL test: all 4 ways valid, LRU build, lookups hit ways 0,1,2,3 -> victim_way=0; round-robin build, 5 misses -> victim_way=1.
REQ-038 SHALL test: ways 1 and 3 dirty, flush_start, flush_ready low 3 cycles -> flush_valid held with flush_way=1, then way 3; flush_busy low after way 3; all invalid.
REQ-039 SHALL test: rst asserted during OFFER -> flush_valid and flush_busy low immediately, write_en accepted next cycle.
